time_set_ctrl: RTL and testbench

- Button-driven controller that configures the running calendar/clock datapath (current_time).
- Snapshots the live time into shadow registers and lets the user edit one field at a time (year, month, day, hour, minute, second) with calendar-legal wrap and clamp rules.
- Computes the matching weekday and commits by driving mode=0 long enough for the datapath's once-per-second load to capture *_d.
- Sits between the debounced button block and current_time.

---
 rtl/time_pkg.sv | 70 +++++++
 rtl/time_set_ctrl_day_of_week.sv | 39 +++
 rtl/time_set_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time-setting controller and the
// calendar helpers it uses.
//   - FSM state codes (3 bits); the six SET states share their code with the
//     field being edited.
//   - FIELD_* codes driven on field_sel for the display blink.
//   - Power-on shadow date/time (2023-05-09 11:59:58, a Tuesday).
//   - Range limits for the time-of-day fields.
//   - is_leap / days_in_month calendar helpers (Gregorian rules).
package time_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN    = 3'd0;
  localparam state_t ST_YEAR   = 3'd1;
  localparam state_t ST_MON    = 3'd2;
  localparam state_t ST_DAY    = 3'd3;
  localparam state_t ST_HOUR   = 3'd4;
  localparam state_t ST_MIN    = 3'd5;
  localparam state_t ST_SEC    = 3'd6;
  localparam state_t ST_COMMIT = 3'd7;

  localparam logic [2:0] FIELD_NONE = 3'd0;
  localparam logic [2:0] FIELD_YEAR = 3'd1;
  localparam logic [2:0] FIELD_MON  = 3'd2;
  localparam logic [2:0] FIELD_DAY  = 3'd3;
  localparam logic [2:0] FIELD_HOUR = 3'd4;
  localparam logic [2:0] FIELD_MIN  = 3'd5;
  localparam logic [2:0] FIELD_SEC  = 3'd6;

  localparam logic [14:0] RST_YEAR  = 15'd2023;
  localparam logic [3:0]  RST_MONTH = 4'd5;
  localparam logic [4:0]  RST_DAY   = 5'd9;
  localparam logic [5:0]  RST_HOUR  = 6'd11;
  localparam logic [5:0]  RST_MIN   = 6'd59;
  localparam logic [5:0]  RST_SEC   = 6'd58;
  localparam logic [3:0]  RST_WEEK  = 4'd2;

  localparam logic [3:0] MONTH_MAX = 4'd12;
  localparam logic [5:0] HOUR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [5:0] SEC_MAX   = 6'd59;

  function automatic logic is_leap(input logic [14:0] year);
    return ((year[1:0] == 2'b00) && ((year % 15'd100) != 15'd0)) ||
           ((year % 15'd400) == 15'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic [14:0] year);
    case (month)
      4'd2:                    return is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  // Blink code for a state: the edited field in SET states, none otherwise.
  function automatic logic [2:0] field_of(input state_t s);
    case (s)
      ST_YEAR: return FIELD_YEAR;
      ST_MON:  return FIELD_MON;
      ST_DAY:  return FIELD_DAY;
      ST_HOUR: return FIELD_HOUR;
      ST_MIN:  return FIELD_MIN;
      ST_SEC:  return FIELD_SEC;
      default: return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/time_set_ctrl_day_of_week.sv
// day_of_week: combinational Gregorian weekday (Zeller's congruence).
//   year  in  15  calendar year (>= 1)
//   month in  4   1..12
//   day   in  5   1..31
//   week  out 4   1=Mon .. 7=Sun
// Uses the +5*J century term so every intermediate stays unsigned.
module day_of_week (
  input  logic [14:0] year,
  input  logic [3:0]  month,
  input  logic [4:0]  day,
  output logic [3:0]  week
);

  logic [14:0] y_adj;
  logic [3:0]  m_adj;
  logic [15:0] kk;
  logic [15:0] jj;
  logic [15:0] sum;
  logic [2:0]  h;

  always_comb begin
    // Jan/Feb count as months 13/14 of the previous year.
    if (month < 4'd3) begin
      y_adj = year - 15'd1;
      m_adj = month + 4'd12;
    end else begin
      y_adj = year;
      m_adj = month;
    end
    kk  = 16'(y_adj % 15'd100);
    jj  = 16'(y_adj / 15'd100);
    sum = 16'(day) + ((16'(m_adj) + 16'd1) * 16'd13) / 16'd5 +
          kk + (kk >> 2) + (jj >> 2) + jj * 16'd5;
    h   = 3'(sum % 16'd7);
    // Zeller gives 0=Sat, 1=Sun, 2=Mon ... 6=Fri.
    week = (h >= 3'd2) ? {1'b0, h - 3'd1} : {1'b0, h + 3'd6};
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven editor for the calendar/clock datapath.
//   clk, rst                         clock, synchronous active-high reset
//   btn_mode/next/up/down            one-cycle debounced button pulses
//   cur_year..cur_sec                live time from the datapath
//   year_d..sec_d                    shadow time presented for loading
//   week_s                           weekday of the shadow date, 1=Mon..7=Sun
//   mode                             1=run, 0=load (held through COMMIT only)
//   field_sel                        field being edited (0 none, 1 yr .. 6 sec)
//   busy                             high whenever not in RUN
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int YEAR_MIN       = 1583,
  parameter int YEAR_MAX       = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_min,
  input  logic [10:0] cur_sec,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [3:0]  mode,
  output logic [2:0]  field_sel,
  output logic        busy
);

  // Hold mode=0 for 1.125 s so the datapath sees at least one second tick.
  localparam int HOLD_CYCLES = CLK_HZ + CLK_HZ / 8;
  localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam int IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [14:0] Y_MIN = 15'(YEAR_MIN);
  localparam logic [14:0] Y_MAX = 15'(YEAR_MAX);

  state_t            state, state_n;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [14:0]       year_n;
  logic [3:0]        month_n, week_n;
  logic [4:0]        day_n, dim_cur, dim_new;
  logic [5:0]        hour_n, min_n, sec_n;
  logic              inc, dec, any_btn;

  // Upper bits of the live-time buses are dropped on load by design.
  logic unused_cur_bits;
  assign unused_cur_bits = ^{cur_year[15], cur_month[5:4], cur_day[10:5],
                             cur_hour[10:6], cur_min[10:6], cur_sec[10:6]};

  function automatic logic [14:0] clamp_year(input logic [14:0] y);
    if (y < Y_MIN)      return Y_MIN;
    else if (y > Y_MAX) return Y_MAX;
    else                return y;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_n = state;
    idle_n  = idle_cnt;
    hold_n  = hold_cnt;
    year_n  = year_d;
    month_n = month_d;
    day_n   = day_d;
    hour_n  = hour_d;
    min_n   = min_d;
    sec_n   = sec_d;
    dim_new = 5'd31;
    inc     = btn_up & ~btn_down;
    dec     = btn_down & ~btn_up;
    any_btn = btn_mode | btn_next | btn_up | btn_down;
    dim_cur = days_in_month(month_d, year_d);

    case (state)
      ST_RUN: begin
        idle_n = '0;
        hold_n = '0;
        if (btn_mode) begin
          year_n  = clamp_year(cur_year[14:0]);
          month_n = cur_month[3:0];
          day_n   = cur_day[4:0];
          hour_n  = cur_hour[5:0];
          min_n   = cur_min[5:0];
          sec_n   = cur_sec[5:0];
          state_n = ST_YEAR;
        end
      end

      ST_COMMIT: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_n  = '0;
          state_n = ST_RUN;
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end

      default: begin
        idle_n = any_btn ? '0 : idle_cnt + IDLE_W'(1);
        if (btn_mode) begin
          hold_n  = '0;
          state_n = ST_COMMIT;
        end else if (btn_next) begin
          state_n = (state == ST_SEC) ? ST_YEAR : state + 3'd1;
        end else if (inc | dec) begin
          case (state)
            ST_YEAR: begin
              if (inc) year_n = (year_d >= Y_MAX) ? Y_MIN : year_d + 15'd1;
              else     year_n = (year_d <= Y_MIN) ? Y_MAX : year_d - 15'd1;
              // Day must stay legal for the new year (Feb 29 -> 28).
              dim_new = days_in_month(month_d, year_n);
              if (day_d > dim_new) day_n = dim_new;
            end
            ST_MON: begin
              if (inc) month_n = (month_d >= MONTH_MAX) ? 4'd1 : month_d + 4'd1;
              else     month_n = (month_d <= 4'd1 || month_d > MONTH_MAX) ?
                                 MONTH_MAX : month_d - 4'd1;
              dim_new = days_in_month(month_n, year_d);
              if (day_d > dim_new) day_n = dim_new;
            end
            ST_DAY: begin
              if (inc) day_n = (day_d >= dim_cur) ? 5'd1 : day_d + 5'd1;
              else     day_n = (day_d <= 5'd1 || day_d > dim_cur) ? dim_cur : day_d - 5'd1;
            end
            ST_HOUR: begin
              if (inc) hour_n = (hour_d >= HOUR_MAX) ? 6'd0 : hour_d + 6'd1;
              else     hour_n = (hour_d == 6'd0 || hour_d > HOUR_MAX) ? HOUR_MAX : hour_d - 6'd1;
            end
            ST_MIN: begin
              if (inc) min_n = (min_d >= MIN_MAX) ? 6'd0 : min_d + 6'd1;
              else     min_n = (min_d == 6'd0 || min_d > MIN_MAX) ? MIN_MAX : min_d - 6'd1;
            end
            default: begin
              if (inc) sec_n = (sec_d >= SEC_MAX) ? 6'd0 : sec_d + 6'd1;
              else     sec_n = (sec_d == 6'd0 || sec_d > SEC_MAX) ? SEC_MAX : sec_d - 6'd1;
            end
          endcase
        end else if (!any_btn && idle_cnt == IDLE_LAST) begin
          // Abandon the edit; shadow keeps whatever was typed.
          idle_n  = '0;
          state_n = ST_RUN;
        end
      end
    endcase
  end

  // Weekday follows the next shadow value so it lands in the same cycle.
  day_of_week u_dow (
    .year  (year_n),
    .month (month_n),
    .day   (day_n),
    .week  (week_n)
  );

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= ST_RUN;
      idle_cnt  <= '0;
      hold_cnt  <= '0;
      year_d    <= RST_YEAR;
      month_d   <= RST_MONTH;
      day_d     <= RST_DAY;
      hour_d    <= RST_HOUR;
      min_d     <= RST_MIN;
      sec_d     <= RST_SEC;
      week_s    <= RST_WEEK;
      mode      <= 4'd1;
      field_sel <= FIELD_NONE;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      idle_cnt  <= idle_n;
      hold_cnt  <= hold_n;
      year_d    <= year_n;
      month_d   <= month_n;
      day_d     <= day_n;
      hour_d    <= hour_n;
      min_d     <= min_n;
      sec_d     <= sec_n;
      week_s    <= week_n;
      mode      <= (state_n == ST_COMMIT) ? 4'd0 : 4'd1;
      field_sel <= field_of(state_n);
      busy      <= (state_n != ST_RUN);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: self-checking bench for time_set_ctrl with CLK_HZ=16 and
// TIMEOUT_CYCLES=50. A calendar model (day counts, modular wrap) tracks the
// expected outputs every cycle; directed sequences pin known dates/lengths.
module tb_time_set_ctrl;

  localparam int CLK_HZ  = 16;
  localparam int TIMEOUT = 50;
  localparam int YMIN    = 1583;
  localparam int YMAX    = 9999;
  localparam int HOLD    = CLK_HZ + CLK_HZ / 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_next, btn_up, btn_down;
  logic [15:0] cur_year;
  logic [5:0]  cur_month;
  logic [10:0] cur_day, cur_hour, cur_min, cur_sec;
  logic [14:0] year_d;
  logic [3:0]  month_d;
  logic [4:0]  day_d;
  logic [5:0]  hour_d, min_d, sec_d;
  logic [3:0]  week_s, mode;
  logic [2:0]  field_sel;
  logic        busy;

  time_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_CYCLES(TIMEOUT),
                  .YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .year_d(year_d), .month_d(month_d), .day_d(day_d),
    .hour_d(hour_d), .min_d(min_d), .sec_d(sec_d),
    .week_s(week_s), .mode(mode), .field_sel(field_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit watch_m0 = 1'b0;
  bit saw_m0   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_state: 0 run, 1..6 editing year..sec, 7 committing
  int m_state, m_y, m_mo, m_d, m_h, m_mi, m_s, m_idle, m_hold;
  int cum_days[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
  int mdays[12]    = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic bit leap(input int y);
    return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
  endfunction

  function automatic int dim(input int mo, input int y);
    return (mo == 2 && leap(y)) ? 29 : mdays[mo-1];
  endfunction

  // Count days from 0001-01-01 (a Monday) and reduce mod 7.
  function automatic int weekday(input int y, input int mo, input int d);
    int yy = y - 1;
    int rd = 365 * yy + yy / 4 - yy / 100 + yy / 400 + cum_days[mo-1] +
             ((mo > 2 && leap(y)) ? 1 : 0) + d;
    return ((rd - 1) % 7) + 1;
  endfunction

  function automatic int clamp_y(input int y);
    int t = y % 32768;
    return (t < YMIN) ? YMIN : (t > YMAX) ? YMAX : t;
  endfunction

  task automatic model_reset();
    m_state = 0; m_idle = 0; m_hold = 0;
    m_y = 2023; m_mo = 5; m_d = 9; m_h = 11; m_mi = 59; m_s = 58;
  endtask

  task automatic model_step();
    bit anyb = btn_mode | btn_next | btn_up | btn_down;
    int dir  = (btn_up && !btn_down) ? 1 : (btn_down && !btn_up) ? -1 : 0;
    int n;
    if (rst) begin
      model_reset();
    end else if (m_state == 0) begin
      if (btn_mode) begin
        m_y = clamp_y(int'(cur_year)); m_mo = int'(cur_month) % 16;
        m_d = int'(cur_day) % 32;      m_h  = int'(cur_hour) % 64;
        m_mi = int'(cur_min) % 64;     m_s  = int'(cur_sec) % 64;
        m_state = 1; m_idle = 0;
      end
    end else if (m_state == 7) begin
      m_hold++;
      if (m_hold == HOLD) m_state = 0;
    end else begin
      m_idle = anyb ? 0 : m_idle + 1;
      if (btn_mode) begin
        m_state = 7; m_hold = 0;
      end else if (btn_next) begin
        m_state = (m_state % 6) + 1;
      end else if (dir != 0) begin
        case (m_state)
          1: m_y  = YMIN + ((m_y - YMIN + dir + (YMAX - YMIN + 1)) % (YMAX - YMIN + 1));
          2: m_mo = ((m_mo - 1 + dir + 12) % 12) + 1;
          3: begin n = dim(m_mo, m_y); m_d = ((m_d - 1 + dir + n) % n) + 1; end
          4: m_h  = (m_h + dir + 24) % 24;
          5: m_mi = (m_mi + dir + 60) % 60;
          default: m_s = (m_s + dir + 60) % 60;
        endcase
        if (m_d > dim(m_mo, m_y)) m_d = dim(m_mo, m_y);
      end else if (!anyb && m_idle == TIMEOUT) begin
        m_state = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Single compare process: every output against the model on each negedge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("year_d",    year_d,    m_y);
      check("month_d",   month_d,   m_mo);
      check("day_d",     day_d,     m_d);
      check("hour_d",    hour_d,    m_h);
      check("min_d",     min_d,     m_mi);
      check("sec_d",     sec_d,     m_s);
      check("week_s",    week_s,    weekday(m_y, m_mo, m_d));
      check("mode",      mode,      (m_state == 7) ? 0 : 1);
      check("busy",      busy,      (m_state == 0) ? 0 : 1);
      check("field_sel", field_sel, (m_state >= 1 && m_state <= 6) ? m_state : 0);
    end
    if (watch_m0 && mode == 4'd0) saw_m0 = 1'b1;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic set_cur(input int y, input int mo, input int d,
                         input int h, input int mi, input int s);
    cur_year = 16'(y); cur_month = 6'(mo); cur_day = 11'(d);
    cur_hour = 11'(h); cur_min = 11'(mi); cur_sec = 11'(s);
  endtask

  task automatic press(input bit m, input bit n, input bit u, input bit d);
    btn_mode = m; btn_next = n; btn_up = u; btn_down = d;
    @(negedge clk);
    btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_cur();
    int y, mo;
    y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                      : int'($urandom_range(YMIN, YMAX));
    mo = $urandom_range(1, 12);
    set_cur(y, mo, $urandom_range(1, dim(mo, clamp_y(y))),
            $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    rst = 1'b1; btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    set_cur(2023, 5, 9, 11, 59, 58);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state, literal values.
    check("rst_year", year_d, 2023);  check("rst_day", day_d, 9);
    check("rst_sec", sec_d, 58);      check("rst_week", week_s, 2);
    check("rst_mode", mode, 1);       check("rst_busy", busy, 0);
    check("rst_field", field_sel, 0);

    // Enter set with live time equal to the reset date.
    press(1, 0, 0, 0);
    check("enter_field", field_sel, 1); check("enter_hour", hour_d, 11);
    check("enter_week", week_s, 2);     check("enter_mode", mode, 1);

    // Leap-year day clamp on month change, then on year change.
    do_reset();
    set_cur(2024, 1, 31, 10, 0, 0);
    press(1, 0, 0, 0); press(0, 1, 0, 0); press(0, 0, 1, 0);
    check("leap_month", month_d, 2); check("leap_day", day_d, 29);
    check("leap_week", week_s, 4);
    repeat (5) press(0, 1, 0, 0);
    check("back_to_year", field_sel, 1);
    press(0, 0, 1, 0);
    check("y2025_year", year_d, 2025); check("y2025_day", day_d, 28);

    // 2100 is not leap: day 28 up wraps to 1.
    do_reset();
    set_cur(2100, 2, 28, 0, 0, 0);
    press(1, 0, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0); press(0, 0, 1, 0);
    check("y2100_day", day_d, 1); check("y2100_month", month_d, 2);

    // Wraps on every range boundary.
    do_reset();
    set_cur(9999, 12, 31, 23, 0, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0); check("year_wrap_up", year_d, 1583);
    press(0, 0, 0, 1); check("year_wrap_dn", year_d, 9999);
    press(0, 1, 0, 0); press(0, 0, 1, 0); check("month_wrap", month_d, 1);
    press(0, 1, 0, 0); press(0, 0, 1, 1); check("updown_day", day_d, 31);
    press(0, 1, 0, 0); press(0, 0, 1, 0); check("hour_wrap", hour_d, 0);
    press(0, 1, 0, 0); press(0, 0, 0, 1); check("min_wrap", min_d, 59);
    press(0, 1, 0, 0); check("at_sec", field_sel, 6);

    // Commit: measure the mode=0 window; a btn_next inside it is ignored.
    press(1, 0, 0, 0);
    zeros = 0;
    for (int i = 0; i < 40 && mode == 4'd0; i++) begin
      zeros++;
      if (i == 3) btn_next = 1'b1;
      @(negedge clk);
      btn_next = 1'b0;
    end
    check("commit_len", zeros, HOLD);
    check("post_commit_mode", mode, 1); check("post_commit_busy", busy, 0);
    check("post_commit_field", field_sel, 0); check("post_commit_min", min_d, 59);

    // Timeout in S_DAY, restarted once by a pulse.
    do_reset();
    set_cur(2022, 3, 15, 8, 30, 0);
    press(1, 0, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
    watch_m0 = 1'b1; saw_m0 = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    check("idle49_field", field_sel, 3);
    press(0, 0, 1, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("restart_field", field_sel, 3);
    @(negedge clk);
    check("timeout_field", field_sel, 0); check("timeout_busy", busy, 0);
    check("timeout_day", day_d, 15);
    watch_m0 = 1'b0;
    check("timeout_no_load", saw_m0, 0);

    // Reset in the middle of a commit.
    set_cur(2030, 7, 4, 1, 2, 3);
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    repeat (5) @(negedge clk);
    check("mid_commit_mode", mode, 0);
    do_reset();
    check("rc_mode", mode, 1);   check("rc_busy", busy, 0);
    check("rc_year", year_d, 2023); check("rc_month", month_d, 5);
    check("rc_day", day_d, 9);   check("rc_hour", hour_d, 11);
    check("rc_week", week_s, 2);

    // Randomized traffic; every fourth block of 300 cycles is idle so
    // commits complete and timeouts fire.
    for (int i = 0; i < 4800; i++) begin
      rand_cur();
      rst = ($urandom_range(0, 999) < 3);
      if ((i / 300) % 4 == 3) begin
        btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
      end else begin
        btn_mode = ($urandom_range(0, 99) < 4);
        btn_next = ($urandom_range(0, 99) < 12);
        btn_up   = ($urandom_range(0, 99) < 20);
        btn_down = ($urandom_range(0, 99) < 20);
      end
      @(negedge clk);
    end
    rst = 0; btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
